// File: rtl/control_bank_out_unit_pkg.sv
// Shared poly-mul memory constants and the request tag carried down the read-return delay line.
package control_bank_out_unit_pkg;

  localparam int NUM_BANKS     = 8;
  localparam int BANK_IDX_W    = 3;
  localparam int COEF_W        = 256;
  localparam int BANK_READ_LAT = 2;

  // One in-flight read: valid, the bank each lane addressed, and whether two lanes shared a bank.
  typedef struct packed {
    logic                              vld;
    logic [NUM_BANKS*BANK_IDX_W-1:0]   idx;
    logic                              conf;
  } bank_tag_t;

  // In-flight counter width; holds up to lat+1 outstanding requests.
  function automatic int cnt_w(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/control_bank_out_unit_delay_line.sv
// Fixed-depth shift register with synchronous clear; shifts every cycle, never stalls.
module control_bank_out_unit_delay_line #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // Stage 0 takes the new tag (or a bubble); older stages move one step toward the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/control_bank_out_unit.sv
// Bank->lane read-return crossbar: remembers which bank every lane read, waits out the
// RAM latency, then hands each lane its bank's word. Conflicts are flagged, never stalled.
module control_bank_out_unit
  import control_bank_out_unit_pkg::*;
#(
  parameter int LANES    = NUM_BANKS,
  parameter int IDX_W    = BANK_IDX_W,
  parameter int DATA_W   = COEF_W,
  parameter int READ_LAT = BANK_READ_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req_valid,
  input  logic [LANES*IDX_W-1:0]  lane_bank,
  input  logic [LANES*DATA_W-1:0] bank_rdata,
  output logic [LANES*DATA_W-1:0] lane_rdata,
  output logic                    lane_rdata_vld,
  output logic                    resp_conflict,
  output logic                    conflict_sticky,
  output logic                    busy
);

  localparam int CNT_W = cnt_w(READ_LAT);

  logic                         conf;
  bank_tag_t                    tag_in, tag_out;
  logic [LANES-1:0][IDX_W-1:0]  tidx;
  logic [LANES-1:0][DATA_W-1:0] bank_w, routed, lane_q;
  logic [CNT_W-1:0]             cnt;

  // Any two lanes aiming at the same bank marks the request as conflicting.
  always_comb begin
    conf = 1'b0;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (lane_bank[i*IDX_W +: IDX_W] == lane_bank[j*IDX_W +: IDX_W]) conf = 1'b1;
  end

  // Idle cycles push an all-zero bubble so stale indices never reach the tail.
  always_comb begin
    tag_in = '0;
    if (rd_req_valid) begin
      tag_in.vld  = 1'b1;
      tag_in.idx  = lane_bank;
      tag_in.conf = conf;
    end
  end

  control_bank_out_unit_delay_line #(
    .WIDTH ($bits(bank_tag_t)),
    .DEPTH (READ_LAT)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign tidx   = tag_out.idx;
  assign bank_w = bank_rdata;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      assign routed[k] = bank_w[tidx[k]];
    end
  endgenerate

  // Output register: capture routed words on a valid tail, otherwise hold data and drop the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q          <= '0;
      lane_rdata_vld  <= 1'b0;
      resp_conflict   <= 1'b0;
      conflict_sticky <= 1'b0;
    end else begin
      lane_rdata_vld  <= tag_out.vld;
      resp_conflict   <= tag_out.vld & tag_out.conf;
      conflict_sticky <= conflict_sticky | (tag_out.vld & tag_out.conf);
      if (tag_out.vld) lane_q <= routed;
    end
  end

  assign lane_rdata = lane_q;

  // Outstanding requests: counted from capture until the cycle after their strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({rd_req_valid, lane_rdata_vld})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: tb/tb_control_bank_out_unit.sv
// Drives three instances (READ_LAT 2, 1, 4) with one stimulus stream and checks all of them
// each cycle against a history-based model, plus literal expectations on the READ_LAT=2 copy.
module tb_control_bank_out_unit;

  localparam int DW = 256;
  localparam int NL = 8;
  localparam int NC = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic [23:0]       lb  = '0;
  logic [NL*DW-1:0]  brd = '0;

  logic [NL*DW-1:0]  ld  [3];
  logic              vld [3];
  logic              cf  [3];
  logic              stk [3];
  logic              bsy [3];

  always #5 clk = ~clk;

  control_bank_out_unit #(.READ_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .rd_req_valid(req), .lane_bank(lb), .bank_rdata(brd),
    .lane_rdata(ld[0]), .lane_rdata_vld(vld[0]), .resp_conflict(cf[0]),
    .conflict_sticky(stk[0]), .busy(bsy[0]));
  control_bank_out_unit #(.READ_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .rd_req_valid(req), .lane_bank(lb), .bank_rdata(brd),
    .lane_rdata(ld[1]), .lane_rdata_vld(vld[1]), .resp_conflict(cf[1]),
    .conflict_sticky(stk[1]), .busy(bsy[1]));
  control_bank_out_unit #(.READ_LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .rd_req_valid(req), .lane_bank(lb), .bank_rdata(brd),
    .lane_rdata(ld[2]), .lane_rdata_vld(vld[2]), .resp_conflict(cf[2]),
    .conflict_sticky(stk[2]), .busy(bsy[2]));

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  bit               req_h [NC];
  logic [23:0]      lb_h  [NC];
  logic [NL*DW-1:0] bk_h  [NC];
  logic [NL*DW-1:0] held  [3];
  bit               stk_m [3];
  int               last_rst = -1;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  function automatic bit pair_conf(input logic [23:0] m);
    bit r = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (m[i*3 +: 3] == m[j*3 +: 3]) r = 1'b1;
    return r;
  endfunction

  task automatic cmp1(input string nm, input int d, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d cyc=%0d got=%0d want=%0d", nm, lat(d), cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NC) begin
      req_h[cyc] = req;
      lb_h[cyc]  = lb;
      bk_h[cyc]  = brd;
      if (cyc > 0) begin
        for (int d = 0; d < 3; d++) begin
          int L, t, nb, lo;
          bit ev, ec;
          L = lat(d);
          ev = 1'b0; ec = 1'b0; nb = 0;
          if (last_rst == cyc - 1) begin
            held[d]  = '0;
            stk_m[d] = 1'b0;
          end else begin
            t = cyc - L - 1;
            ev = (t > last_rst) && req_h[t];
            if (ev) begin
              ec = pair_conf(lb_h[t]);
              for (int k = 0; k < NL; k++)
                held[d][k*DW +: DW] = bk_h[cyc-1][int'(lb_h[t][k*3 +: 3])*DW +: DW];
            end
            stk_m[d] = stk_m[d] | ec;
            lo = (cyc - L - 1 > last_rst + 1) ? cyc - L - 1 : last_rst + 1;
            for (int u = lo; u < cyc; u++) if (req_h[u]) nb++;
          end
          cmp1("model_vld", d, int'(vld[d]), int'(ev));
          cmp1("model_conflict", d, int'(cf[d]), int'(ec));
          cmp1("model_sticky", d, int'(stk[d]), int'(stk_m[d]));
          cmp1("model_busy", d, int'(bsy[d]), int'(nb != 0));
          n_cmp++;
          if (ld[d] !== held[d]) begin
            n_bad++;
            for (int k = 0; k < NL; k++)
              if (ld[d][k*DW +: DW] !== held[d][k*DW +: DW]) begin
                $display("FAIL model_data lat=%0d cyc=%0d lane=%0d got=%h want=%h",
                         lat(d), cyc, k, ld[d][k*DW +: DW], held[d][k*DW +: DW]);
                break;
              end
          end
        end
      end
      if (rst) last_rst = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int m [8]);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(m[k]);
    return r;
  endfunction

  function automatic logic [23:0] rot(input int s);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'((k + s) % 8);
    return r;
  endfunction

  function automatic logic [NL*DW-1:0] banks(input logic [255:0] base);
    logic [NL*DW-1:0] w;
    for (int b = 0; b < NL; b++) w[b*DW +: DW] = base + 256'(b);
    return w;
  endfunction

  function automatic logic [255:0] lane2(input int k);
    return ld[0][k*DW +: DW];
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c0;
    int m [8];

    // reset state
    while (cyc < 2) tick;
    @(negedge clk);
    lit("reset_vld", 256'(vld[0]), 256'd0);
    lit("reset_busy", 256'(bsy[0]), 256'd0);
    lit("reset_sticky", 256'(stk[0]), 256'd0);
    lit("reset_data", lane2(3), 256'd0);
    tick;
    rst = 1'b0;

    // 1: identity map, single request at cycle 10
    brd = banks(256'h100);
    while (cyc < 10) tick;
    req = 1'b1; lb = rot(0);
    tick;
    req = 1'b0;
    tick;
    @(negedge clk);
    lit("ident_no_early_strobe", 256'(vld[0]), 256'd0);
    tick;
    @(negedge clk);
    lit("ident_strobe", 256'(vld[0]), 256'd1);
    lit("ident_conflict", 256'(cf[0]), 256'd0);
    for (int k = 0; k < 8; k++) lit("ident_lane", lane2(k), 256'h100 + 256'(k));
    tick;
    @(negedge clk);
    lit("ident_strobe_drop", 256'(vld[0]), 256'd0);
    repeat (6) tick;

    // 2: rotation k -> (k+3)%8, four back-to-back, bank data changes each cycle
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      req = (j < 4); lb = rot(3);
      brd = banks(256'(cyc) * 256'h1000);
      @(negedge clk);
      if (j >= 1 && j <= 6) lit("rot_busy", 256'(bsy[0]), 256'd1);
      if (j >= 3 && j <= 6) lit("rot_strobe", 256'(vld[0]), 256'd1);
      if (j == 3) begin
        lit("rot_lane0", lane2(0), 256'(c0 + 2) * 256'h1000 + 256'd3);
        lit("rot_lane7", lane2(7), 256'(c0 + 2) * 256'h1000 + 256'd2);
      end
      tick;
    end
    req = 1'b0;
    repeat (4) tick;

    // 3: lanes 0 and 5 share bank 2
    brd = banks(256'h3000);
    m = '{2, 1, 0, 3, 4, 2, 6, 7};
    req = 1'b1; lb = pk(m);
    tick;
    req = 1'b0;
    tick; tick;
    @(negedge clk);
    lit("conf_strobe", 256'(vld[0]), 256'd1);
    lit("conf_flag", 256'(cf[0]), 256'd1);
    lit("conf_lane0", lane2(0), 256'h3002);
    lit("conf_lane5", lane2(5), 256'h3002);
    lit("conf_lane2", lane2(2), 256'h3000);
    tick;
    @(negedge clk);
    lit("conf_flag_drop", 256'(cf[0]), 256'd0);
    lit("conf_sticky", 256'(stk[0]), 256'd1);
    repeat (5) tick;
    @(negedge clk);
    lit("conf_sticky_late", 256'(stk[0]), 256'd1);

    // 4: requests at relative cycles 0, 2, 3
    for (int j = 0; j < 9; j++) begin
      req = (j == 0 || j == 2 || j == 3); lb = rot(1);
      brd = banks(256'(j + 1) * 256'h10000);
      @(negedge clk);
      case (j)
        3: begin lit("bub_s3", 256'(vld[0]), 256'd1); lit("bub_d3", lane2(0), 256'h30001); end
        4: begin lit("bub_gap", 256'(vld[0]), 256'd0); lit("bub_hold", lane2(0), 256'h30001); end
        5: begin lit("bub_s5", 256'(vld[0]), 256'd1); lit("bub_d5", lane2(0), 256'h50001); end
        6: begin lit("bub_s6", 256'(vld[0]), 256'd1); lit("bub_d6", lane2(0), 256'h60001);
                 lit("bub_busy6", 256'(bsy[0]), 256'd1); end
        7: begin lit("bub_busy7", 256'(bsy[0]), 256'd0); lit("bub_s7", 256'(vld[0]), 256'd0); end
        default: ;
      endcase
      tick;
    end
    req = 1'b0;
    repeat (4) tick;

    // 5: two requests, reset one cycle before the first strobe
    brd = banks(256'h7700);
    for (int j = 0; j < 8; j++) begin
      req = (j < 2); rst = (j == 2); lb = rot(2);
      @(negedge clk);
      if (j >= 3) begin
        lit("rst_no_strobe", 256'(vld[0]), 256'd0);
        lit("rst_busy", 256'(bsy[0]), 256'd0);
        lit("rst_sticky", 256'(stk[0]), 256'd0);
        lit("rst_data", lane2(1), 256'd0);
      end
      tick;
    end
    req = 1'b0; rst = 1'b0;
    repeat (3) tick;

    // 6: random permutations, ~10% conflicts, checked on all three latencies by the model
    for (int j = 0; j < 150; j++) begin
      for (int k = 0; k < 8; k++) m[k] = k;
      for (int k = 7; k > 0; k--) begin
        int r, tmp;
        r = $urandom_range(0, k);
        tmp = m[k]; m[k] = m[r]; m[r] = tmp;
      end
      if ($urandom_range(0, 9) == 0) begin
        int a, b;
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        m[a] = m[b];
      end
      req = ($urandom_range(0, 9) < 7);
      lb  = pk(m);
      for (int w = 0; w < NL * DW / 32; w++) brd[w*32 +: 32] = $urandom;
      tick;
    end
    req = 1'b0;
    repeat (8) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
